// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART types, widths and baud divider helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned DATA_BITS          = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Clock cycles per oversample tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_freq / (baud * os);
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : baud_tick_gen
// Purpose  : Free-running divide-by-DIV strobe with phase-aligning clear.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] c_last_cnt = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_last_cnt)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A clear restarts the phase, so the stale terminal count must not strobe.
  assign tick = (r_cnt == c_last_cnt) && !clr;

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_oversampled
// Purpose  : 8N1 UART receiver, LSB first, oversampled with mid-bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] c_half_bit = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] c_full_bit = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    c_last_bit = 3'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  uart_state_e          r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_sh;
  logic                 w_rx_s;
  logic                 w_tick;
  logic                 w_start_det;

  // Reset to idle-high so releasing rst never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx_s      = r_sync[1];
  assign w_start_det = (r_state == IDLE) && !w_rx_s;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_start_det),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_sh       <= '0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == c_half_bit) begin
              r_tick_cnt <= '0;
              r_state    <= w_rx_s ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == c_full_bit) begin
              r_sh       <= {w_rx_s, r_sh[DATA_BITS-1:1]};
              r_tick_cnt <= '0;
              if (r_bit_cnt == c_last_bit) begin
                r_state <= STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == c_full_bit) begin
              r_tick_cnt <= '0;
              if (w_rx_s) begin
                rx_data <= r_sh;
                rx_done <= 1'b1;
                r_state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= BREAK;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          // A held-low line reports once and then waits for the line to recover.
          if (w_rx_s) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_oversampled
// Purpose  : Directed self-checking bench for uart_rx_oversampled (DIV = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

  localparam int unsigned CLK_FREQ   = 3_200_000;
  localparam int unsigned BAUD_RATE  = 100_000;
  localparam int unsigned OVERSAMPLE = 8;
  localparam int          BP         = 32;   // clk per bit: DIV 4 x 8 ticks

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         both_cnt = 0;
  int         busy_bad = 0;
  logic [7:0] last_data = 8'h00;
  time        fall_time = 0;
  time        done_time = 0;

  uart_rx_oversampled #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt  <= done_cnt + 1;
      last_data <= rx_data;
      done_time <= $time;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (rx_done && frame_err) both_cnt <= both_cnt + 1;
    if (rx_done && rx_busy) busy_bad <= busy_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bp, input logic stop_bit);
    fall_time = $time;
    rx = 1'b0;
    repeat (bp) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (bp) @(negedge clk);
    end
    rx = stop_bit;
    repeat (bp) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BP) @(negedge clk);
  endtask

  int d0, e0, lat;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_done", 32'(rx_done), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_rx_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    idle_bits(2);

    // Single 0x55 frame, latency 2 + (4 + 72) ticks * 4 clk, seen half a clk late.
    send_frame(8'h55, BP, 1'b1);
    idle_bits(1);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'h55);
    check("t1_frame_err", 32'(err_cnt), 32'd0);
    check("t1_busy_with_done", 32'(busy_bad), 32'd0);
    check("t1_idle", 32'(rx_busy), 32'h0);
    lat = int'((done_time - fall_time) / 10);
    check("t1_latency", 32'((lat >= 306) && (lat <= 308)), 32'h1);

    // Byte sweep.
    d0 = done_cnt;
    for (int i = 0; i < 256; i += 5) begin
      send_frame(8'(i), BP, 1'b1);
      idle_bits(1);
      check("t2_rx_data", 32'(last_data), 32'(i));
    end
    check("t2_done_count", 32'(done_cnt - d0), 32'd52);

    // Short low glitch is rejected at mid start bit.
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    check("t3_back_idle", 32'(rx_busy), 32'h0);
    idle_bits(1);
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);
    check("t3_no_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'hA3, BP, 1'b1);
    idle_bits(1);
    check("t3_rx_data", 32'(rx_data), 32'hA3);

    // Framing error followed by a held-low break.
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, BP, 1'b0);
    rx = 1'b0;
    repeat (2 * BP) @(negedge clk);
    check("t4_busy_in_break", 32'(rx_busy), 32'h1);
    idle_bits(1);
    check("t4_one_err", 32'(err_cnt - e0), 32'd1);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    check("t4_rx_data_kept", 32'(rx_data), 32'hA3);
    check("t4_idle", 32'(rx_busy), 32'h0);
    send_frame(8'hC3, BP, 1'b1);
    idle_bits(1);
    check("t4_rx_data", 32'(rx_data), 32'hC3);

    // Back-to-back frames and off-nominal bit periods.
    d0 = done_cnt;
    send_frame(8'h00, BP, 1'b1);
    check("t5_first", 32'(rx_data), 32'h00);
    send_frame(8'hFF, BP, 1'b1);
    idle_bits(1);
    check("t5_second", 32'(rx_data), 32'hFF);
    check("t5_done_count", 32'(done_cnt - d0), 32'd2);
    send_frame(8'h96, 31, 1'b1);
    idle_bits(1);
    check("t5_fast", 32'(rx_data), 32'h96);
    send_frame(8'h69, 33, 1'b1);
    idle_bits(1);
    check("t5_slow", 32'(rx_data), 32'h69);

    // Reset in the middle of data bit 4 of 0x81.
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (BP) @(negedge clk);
    rx = 1'b1;
    repeat (BP) @(negedge clk);
    rx = 1'b0;
    repeat (3 * BP + BP / 2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_rst_rx_data", 32'(rx_data), 32'h00);
    check("t6_rst_done", 32'(rx_done), 32'h0);
    check("t6_rst_err", 32'(frame_err), 32'h0);
    check("t6_rst_busy", 32'(rx_busy), 32'h0);
    rx  = 1'b1;
    rst = 1'b0;
    idle_bits(12);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_no_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h7E, BP, 1'b1);
    idle_bits(1);
    check("t6_rx_data", 32'(rx_data), 32'h7E);
    check("t6_done_count", 32'(done_cnt - d0), 32'd1);

    check("never_both_strobes", 32'(both_cnt), 32'd0);
    check("busy_low_with_done", 32'(busy_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
